// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control unit: Moore FSM with registered control outputs.
// pcEn is the one Mealy output; write strobes are masked while rst is high.
module mc_control_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        iord,
    output logic        memRead,
    output logic        memWrite,
    output logic        irWrite,
    output logic        regDst,
    output logic        memToReg,
    output logic        regWrite,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [2:0]  aluCtrl,
    output logic [1:0]  pcSrc,
    output logic        pcEn,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTEXEC   = 4'd6,
        S_RTWB     = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       pc_write_cond;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic funct_known(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: return ALU_SUB;
            6'b100100: return ALU_AND;
            6'b100101: return ALU_OR;
            6'b101010: return ALU_SLT;
            default:   return ALU_ADD;
        endcase
    endfunction

    // Control word for a state; rt_alu only matters for RTEXEC.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [2:0] rt_alu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_ctrl  = ALU_ADD;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_ctrl  = ALU_ADD;
            end
            S_MEMADR, S_ADDIEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_ctrl  = ALU_ADD;
            end
            S_MEMRD:  begin c.iord = 1'b1; c.mem_read  = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
            S_RTEXEC: begin c.alu_src_a = 1'b1; c.alu_ctrl = rt_alu; end
            S_RTWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_ctrl      = ALU_SUB;
                c.pc_src        = 2'b01;
                c.pc_write_cond = 1'b1;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    state_t cur;
    state_t nxt;
    ctrl_t  ctrl;
    logic   rt_ok;
    logic   set_illegal;
    logic   retire;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nxt         = S_FETCH;
        set_illegal = 1'b0;
        retire      = 1'b0;
        case (cur)
            S_FETCH: nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     nxt = S_RTEXEC;
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_ADDI:      nxt = S_ADDIEXEC;
                    OP_J:         nxt = S_JUMP;
                    default:      set_illegal = 1'b1;
                endcase
            end
            S_MEMADR:   nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    nxt = S_MEMWB;
            S_RTEXEC:   if (rt_ok) nxt = S_RTWB; else set_illegal = 1'b1;
            S_ADDIEXEC: nxt = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_RTWB, S_BEQ, S_ADDIWB, S_JUMP: retire = 1'b1;
            default:    nxt = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state, so they are valid for the whole state.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= S_FETCH;
            ctrl    <= ctrl_of(S_FETCH, ALU_ADD);
            rt_ok   <= 1'b0;
            illegal <= 1'b0;
            retired <= 16'd0;
        end else begin
            cur  <= nxt;
            ctrl <= ctrl_of(nxt, funct_alu(funct));
            if (cur == S_DECODE) rt_ok <= funct_known(funct);
            if (set_illegal) illegal <= 1'b1;
            if (retire) retired <= retired + 16'd1;
        end
    end

    assign state    = cur;
    assign iord     = ctrl.iord;
    assign regDst   = ctrl.reg_dst;
    assign memToReg = ctrl.mem_to_reg;
    assign aluSrcA  = ctrl.alu_src_a;
    assign aluSrcB  = ctrl.alu_src_b;
    assign aluCtrl  = ctrl.alu_ctrl;
    assign pcSrc    = ctrl.pc_src;
    assign memRead  = ctrl.mem_read  & ~rst;
    assign memWrite = ctrl.mem_write & ~rst;
    assign irWrite  = ctrl.ir_write  & ~rst;
    assign regWrite = ctrl.reg_write & ~rst;
    assign pcEn     = (ctrl.pc_write | (ctrl.pc_write_cond & zero)) & ~rst;

endmodule
